// File: rtl/uart_menu_ctrl_if.sv
// Bus bundle for uart_menu_ctrl: rx/tx handshakes, ROM port, message table,
// toggle outputs, status. master = controller side, slave = environment.
interface uart_menu_ctrl_if #(
  parameter int NUM_MSG = 4,
  parameter int NUM_OUT = 2,
  parameter int ADDR_W  = 10
);
  logic                      rx_done_tick;
  logic [7:0]                rx_data;
  logic                      tx_start;
  logic [7:0]                tx_din;
  logic                      tx_done_tick;
  logic [ADDR_W-1:0]         rom_addr;
  logic [7:0]                rom_dout;
  logic [NUM_MSG*ADDR_W-1:0] msg_start;
  logic [NUM_MSG*ADDR_W-1:0] msg_stop;
  logic [NUM_OUT-1:0]        ctrl_out;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    input  rx_done_tick, rx_data,
    input  tx_done_tick, rom_dout,
    input  msg_start, msg_stop,
    output tx_start, tx_din, rom_addr,
    output ctrl_out, busy, timeout_err
  );

  modport slave (
    output rx_done_tick, rx_data,
    output tx_done_tick, rom_dout,
    output msg_start, msg_stop,
    input  tx_start, tx_din, rom_addr,
    input  ctrl_out, busy, timeout_err
  );
endinterface

// File: rtl/uart_menu_ctrl.sv
// UART menu controller: streams ROM messages to uart_tx, decodes rx commands.
// Ports: clk, reset (async high), bus (uart_menu_ctrl_if.master).
module uart_menu_ctrl #(
  parameter int                 NUM_MSG     = 4,
  parameter int                 NUM_OUT     = 2,
  parameter int                 ADDR_W      = 10,
  parameter logic [7:0]         BASE_CHAR   = 8'h31,
  parameter int                 TIMEOUT_CYC = 100000000,
  parameter bit                 BOOT_MSG_EN = 1'b1,
  parameter logic [NUM_OUT-1:0] OUT_INIT    = '0
) (
  input  logic             clk,
  input  logic             reset,
  uart_menu_ctrl_if.master bus
);

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [8:0] N_MSG = 9'(NUM_MSG);
  localparam logic [8:0] N_END = 9'(NUM_MSG + NUM_OUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_START,
    S_SEND,
    S_NEXT
  } state_e;

  localparam state_e RST_STATE = BOOT_MSG_EN ? S_ADDR : S_CMD;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  stop_q, stop_d;
  logic [7:0]         din_q, din_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [NUM_OUT-1:0] ctrl_q, ctrl_d;

  logic       tx_start;
  logic       to_err;
  logic [7:0] idx;
  logic [7:0] oidx;

  assign idx  = bus.rx_data - BASE_CHAR;
  assign oidx = idx - N_MSG[7:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stop_d   = stop_q;
    din_d    = din_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    ctrl_d   = ctrl_q;
    tx_start = 1'b0;
    to_err   = 1'b0;

    // ESC is the only byte honoured while a message is in flight
    if (state_q != S_CMD && bus.rx_done_tick &&
        bus.rx_data == 8'h1B) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      S_CMD: begin
        if (bus.rx_done_tick) begin
          if ({1'b0, idx} < N_MSG) begin
            sel_d   = IDX_W'(idx);
            state_d = S_ADDR;
          end else if ({1'b0, idx} < N_END) begin
            ctrl_d = ctrl_q ^ (NUM_OUT'(1) << oidx);
          end else if (bus.rx_data == 8'h3F) begin
            sel_d   = '0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        // table is sampled here once per message
        addr_d  = bus.msg_start[sel_q*ADDR_W +: ADDR_W];
        stop_d  = bus.msg_stop[sel_q*ADDR_W +: ADDR_W];
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        din_d   = bus.rom_dout;
        state_d = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_done_tick) begin
          state_d = S_NEXT;
        end else if (cnt_q == CNT_LAST) begin
          to_err  = 1'b1;
          abort_d = 1'b0;
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        // stop < start ends after the first byte
        if (abort_q || addr_q >= stop_q) begin
          abort_d = 1'b0;
          state_d = S_CMD;
        end else begin
          addr_d  = (addr_q == '1) ? addr_q : addr_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_CMD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      stop_q  <= '0;
      din_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      ctrl_q  <= OUT_INIT;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stop_q  <= stop_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.tx_start    = tx_start;
  assign bus.tx_din      = din_q;
  assign bus.rom_addr    = addr_q;
  assign bus.ctrl_out    = ctrl_q;
  assign bus.busy        = (state_q != S_CMD);
  assign bus.timeout_err = to_err;

endmodule
